// File: rtl/riscv_mem_pkg.sv
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared types and widths for the fetch/data memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF   = 1'b0,
        GNT_DATA = 1'b1
    } arb_grant_t;

    function automatic logic is_misaligned(input logic [1:0] i_addr_lsb);
        return i_addr_lsb != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_arbiter_if.sv
// ============================================================================
//  Module      : memory_arbiter_if
//  Description : Fetch, data and memory-side signals of the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_arbiter_if;
    import riscv_mem_pkg::*;

    // fetch port
    logic              if_read;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              stall_if;
    // MEM-stage data port
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] memory_addr;
    logic [DATA_W-1:0] data_to_write;
    logic [DATA_W-1:0] read_data_from_memory_controller;
    logic              data_ready;
    logic              data_misaligned;
    logic              stall_mem;
    // memory controller side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_read, if_addr, read, write, memory_addr, data_to_write,
               mem_rdata, mem_ack,
        output if_rdata, if_ready, stall_if, read_data_from_memory_controller,
               data_ready, data_misaligned, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_read, if_addr, read, write, memory_addr, data_to_write,
               mem_rdata, mem_ack,
        input  if_rdata, if_ready, stall_if, read_data_from_memory_controller,
               data_ready, data_misaligned, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_picker.sv
// ============================================================================
//  Module      : mem_arb_picker
//  Description : Combinational grant selection with alternating tie-break.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_picker
    import riscv_mem_pkg::*;
(
    input  wire logic       i_if_read,
    input  wire logic       i_data_req,
    input  arb_grant_t      i_last_grant,
    output arb_grant_t      o_grant,
    output logic            o_valid
);

    always_comb begin
        o_valid = i_if_read | i_data_req;
        o_grant = GNT_IF;
        // data wins a tie unless it also won the previous grant
        if (i_data_req && (!i_if_read || (i_last_grant == GNT_IF))) begin
            o_grant = GNT_DATA;
        end
    end

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
//  Module      : memory_arbiter
//  Description : Shares one single-port memory between fetch and MEM stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_arbiter
    import riscv_mem_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    memory_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    arb_grant_t        r_grant;
    arb_grant_t        r_last_grant;
    arb_grant_t        w_pick_grant;
    logic              w_pick_valid;
    logic              w_data_req;
    logic              w_misaligned;
    logic              w_start;
    logic              w_skip;
    logic              w_capture;
    logic              r_misaligned;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_data_rdata;

    assign w_data_req   = bus.read | bus.write;
    assign w_misaligned = is_misaligned(bus.memory_addr[1:0]);

    mem_arb_picker u_picker (
        .i_if_read    (bus.if_read),
        .i_data_req   (w_data_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_grant),
        .o_valid      (w_pick_valid)
    );

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_skip       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    if ((w_pick_grant == GNT_DATA) && w_misaligned) begin
                        w_skip       = 1'b1;
                        w_state_next = DONE;
                    end else begin
                        w_start      = 1'b1;
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant      <= GNT_IF;
            r_last_grant <= GNT_IF;
            r_misaligned <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_rdata   <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_start || w_skip) begin
                r_grant      <= w_pick_grant;
                r_last_grant <= w_pick_grant;
                r_misaligned <= w_skip;
            end
            if (w_start) begin
                if (w_pick_grant == GNT_DATA) begin
                    // a simultaneous read+write is a store
                    r_mem_we    <= bus.write;
                    r_mem_addr  <= bus.memory_addr;
                    r_mem_wdata <= bus.data_to_write;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= bus.if_addr;
                end
            end
            if (w_capture && !r_mem_we) begin
                if (r_grant == GNT_IF) begin
                    r_if_rdata   <= bus.mem_rdata;
                end else begin
                    r_data_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req   = (r_state == BUSY);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    assign bus.if_ready        = (r_state == DONE) && (r_grant == GNT_IF);
    assign bus.data_ready      = (r_state == DONE) && (r_grant == GNT_DATA);
    assign bus.data_misaligned = bus.data_ready && r_misaligned;
    assign bus.if_rdata        = r_if_rdata;
    assign bus.read_data_from_memory_controller = r_data_rdata;

    assign bus.stall_if  = bus.if_read & ~bus.if_ready;
    assign bus.stall_mem = w_data_req & ~bus.data_ready;

endmodule

`default_nettype wire
